usb_endpoint_poll_table: RTL and testbench

//  Stores endpoints emitted by usb_descriptor_parser in a small table and schedules IN polls for them.

---
 rtl/usb_endpoint_poll_table.sv | 218 +++++++++++++++++++++
 tb/tb_usb_endpoint_poll_table.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_endpoint_poll_table.sv
// Endpoint table fed by the descriptor parser; counts bInterval frames per entry and
// offers due IN endpoints round-robin to the token engine (1 clk pending->offer, offer held until ready).
module usb_endpoint_poll_table #(
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             ep_valid,
  input  logic [3:0]       ep_number,
  input  logic             ep_direction,
  input  logic [1:0]       ep_type,
  input  logic [10:0]      ep_max_packet,
  input  logic [7:0]       ep_interval,
  input  logic [7:0]       ep_iface,
  input  logic             sof_tick,
  output logic             poll_valid,
  input  logic             poll_ready,
  output logic [3:0]       poll_number,
  output logic [1:0]       poll_type,
  output logic [10:0]      poll_max_packet,
  output logic [7:0]       poll_iface,
  output logic [IDX_W-1:0] poll_index,
  output logic [IDX_W:0]   entry_count,
  output logic             full,
  output logic             overflow
);

  typedef struct packed {
    logic        valid;
    logic        pending;
    logic [3:0]  number;
    logic [1:0]  ttype;
    logic [10:0] mps;
    logic [7:0]  iface;
    logic [7:0]  interval;
    logic [7:0]  cdown;
  } entry_t;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  entry_t            tbl_q [DEPTH];
  entry_t            tbl_d [DEPTH];
  state_t            state_q;
  logic              poll_valid_q;
  logic [3:0]        poll_number_q;
  logic [1:0]        poll_type_q;
  logic [10:0]       poll_mps_q;
  logic [7:0]        poll_iface_q;
  logic [IDX_W-1:0]  poll_index_q;
  logic [IDX_W-1:0]  rr_q;
  logic [IDX_W:0]    count_q;
  logic              overflow_q;
  logic              repend_q;

  logic              hit, free_found, ins_en, ins_wr, ins_new, ins_drop, accept;
  logic [IDX_W-1:0]  hit_idx, free_idx, ins_slot;
  logic [7:0]        eff_interval;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx, rr_j;
  logic [IDX_W:0]    rr_sum;

  // Only IN endpoints are stored, so the number alone identifies a key among valid slots.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_q[i].valid && tbl_q[i].number == ep_number && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!tbl_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign ins_en       = ep_valid && ep_direction;
  assign ins_wr       = ins_en && (hit || free_found);
  assign ins_new      = ins_en && !hit && free_found;
  assign ins_drop     = ins_en && !hit && !free_found;
  assign ins_slot     = hit ? hit_idx : free_idx;
  assign eff_interval = (ep_interval == 8'd0) ? 8'd1 : ep_interval;
  assign accept       = (state_q == S_OFFER) && poll_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
      if (sof_tick && tbl_q[i].valid && !tbl_q[i].pending) begin
        if (tbl_q[i].cdown > 8'd1) begin
          tbl_d[i].cdown = tbl_q[i].cdown - 8'd1;
        end else begin
          tbl_d[i].pending = 1'b1;
          tbl_d[i].cdown   = 8'd0;
        end
      end
      // A slot rewritten while offered stays pending so the new fields get polled.
      if (accept && poll_index_q == IDX_W'(i) && !repend_q) begin
        tbl_d[i].pending = 1'b0;
        tbl_d[i].cdown   = tbl_q[i].interval;
      end
      if (ins_wr && ins_slot == IDX_W'(i)) begin
        tbl_d[i].valid    = 1'b1;
        tbl_d[i].pending  = 1'b1;
        tbl_d[i].number   = ep_number;
        tbl_d[i].ttype    = ep_type;
        tbl_d[i].mps      = ep_max_packet;
        tbl_d[i].iface    = ep_iface;
        tbl_d[i].interval = eff_interval;
        tbl_d[i].cdown    = 8'd0;
      end
      if (clear) begin
        tbl_d[i] = '0;
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_sum    = '0;
    rr_j      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rr_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (rr_sum >= (IDX_W+1)'(DEPTH)) begin
        rr_sum = rr_sum - (IDX_W+1)'(DEPTH);
      end
      rr_j = rr_sum[IDX_W-1:0];
      if (!sel_found && tbl_q[rr_j].valid && tbl_q[rr_j].pending) begin
        sel_found = 1'b1;
        sel_idx   = rr_j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      if (clear) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (ins_new) count_q <= count_q + 1'b1;
        if (ins_drop) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      poll_valid_q  <= 1'b0;
      poll_number_q <= '0;
      poll_type_q   <= '0;
      poll_mps_q    <= '0;
      poll_iface_q  <= '0;
      poll_index_q  <= '0;
      rr_q          <= '0;
      repend_q      <= 1'b0;
    end else if (clear) begin
      state_q       <= S_IDLE;
      poll_valid_q  <= 1'b0;
      poll_number_q <= '0;
      poll_type_q   <= '0;
      poll_mps_q    <= '0;
      poll_iface_q  <= '0;
      poll_index_q  <= '0;
      rr_q          <= '0;
      repend_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            state_q       <= S_OFFER;
            poll_valid_q  <= 1'b1;
            poll_number_q <= tbl_q[sel_idx].number;
            poll_type_q   <= tbl_q[sel_idx].ttype;
            poll_mps_q    <= tbl_q[sel_idx].mps;
            poll_iface_q  <= tbl_q[sel_idx].iface;
            poll_index_q  <= sel_idx;
            repend_q      <= ins_wr && (ins_slot == sel_idx);
          end
        end
        S_OFFER: begin
          if (ins_wr && ins_slot == poll_index_q) repend_q <= 1'b1;
          if (poll_ready) begin
            state_q      <= S_IDLE;
            poll_valid_q <= 1'b0;
            repend_q     <= 1'b0;
            rr_q         <= (poll_index_q == IDX_W'(DEPTH-1)) ? '0 : poll_index_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign poll_valid      = poll_valid_q;
  assign poll_number     = poll_number_q;
  assign poll_type       = poll_type_q;
  assign poll_max_packet = poll_mps_q;
  assign poll_iface      = poll_iface_q;
  assign poll_index      = poll_index_q;
  assign entry_count     = count_q;
  assign full            = (count_q == (IDX_W+1)'(DEPTH));
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_usb_endpoint_poll_table.sv
// Directed bench for usb_endpoint_poll_table: inserts, frame countdown, round-robin, backpressure, full/overflow, reset.
module tb_usb_endpoint_poll_table;
  logic        clk = 1'b0;
  logic        rst_n, clear, ep_valid, ep_direction, sof_tick, poll_ready;
  logic [3:0]  ep_number;
  logic [1:0]  ep_type;
  logic [10:0] ep_max_packet;
  logic [7:0]  ep_interval, ep_iface;
  logic        poll_valid, full, overflow;
  logic [3:0]  poll_number;
  logic [1:0]  poll_type;
  logic [10:0] poll_max_packet;
  logic [7:0]  poll_iface;
  logic [1:0]  poll_index;
  logic [2:0]  entry_count;

  int checks = 0;
  int errors = 0;

  usb_endpoint_poll_table #(.DEPTH(4), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ep_valid(ep_valid), .ep_number(ep_number),
    .ep_direction(ep_direction), .ep_type(ep_type), .ep_max_packet(ep_max_packet),
    .ep_interval(ep_interval), .ep_iface(ep_iface), .sof_tick(sof_tick),
    .poll_valid(poll_valid), .poll_ready(poll_ready), .poll_number(poll_number),
    .poll_type(poll_type), .poll_max_packet(poll_max_packet), .poll_iface(poll_iface),
    .poll_index(poll_index), .entry_count(entry_count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ins(input logic [3:0] num, input logic dir, input logic [1:0] typ,
                     input logic [10:0] mps, input logic [7:0] intv, input logic [7:0] ifc);
    ep_number = num; ep_direction = dir; ep_type = typ;
    ep_max_packet = mps; ep_interval = intv; ep_iface = ifc;
    ep_valid = 1'b1;
    tick();
    ep_valid = 1'b0;
  endtask

  task automatic sof();
    sof_tick = 1'b1;
    tick();
    sof_tick = 1'b0;
  endtask

  task automatic acc();
    poll_ready = 1'b1;
    tick();
    poll_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_poll(input string tag);
    int n = 0;
    while (!poll_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, poll_valid}, 32'd1);
  endtask

  logic [3:0]  held_num;
  logic [10:0] held_mps;
  logic        stable;

  initial begin
    rst_n = 1'b0; clear = 1'b0; ep_valid = 1'b0; ep_direction = 1'b0; sof_tick = 1'b0;
    poll_ready = 1'b0; ep_number = '0; ep_type = '0; ep_max_packet = '0;
    ep_interval = '0; ep_iface = '0;
    ticks(2);
    chk("rst_poll_valid", {31'd0, poll_valid}, 32'd0);
    chk("rst_count", {29'd0, entry_count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_poll_number", {28'd0, poll_number}, 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // first insert, one-clock offer latency
    ins(4'd1, 1'b1, 2'b11, 11'd8, 8'd10, 8'd2);
    chk("ins_lat_pre", {31'd0, poll_valid}, 32'd0);
    tick();
    chk("ins_lat_post", {31'd0, poll_valid}, 32'd1);
    chk("ins_number", {28'd0, poll_number}, 32'd1);
    chk("ins_mps", {21'd0, poll_max_packet}, 32'd8);
    chk("ins_type", {30'd0, poll_type}, 32'd3);
    chk("ins_iface", {24'd0, poll_iface}, 32'd2);
    chk("ins_index", {30'd0, poll_index}, 32'd0);
    chk("ins_count", {29'd0, entry_count}, 32'd1);
    acc();
    chk("acc_drop", {31'd0, poll_valid}, 32'd0);

    // interval 10: nine frames quiet, tenth polls
    for (int f = 0; f < 9; f++) begin
      sof();
      ticks(2);
      chk("intv_quiet", {31'd0, poll_valid}, 32'd0);
    end
    sof();
    tick();
    chk("intv_tenth", {31'd0, poll_valid}, 32'd1);
    chk("intv_number", {28'd0, poll_number}, 32'd1);
    acc();

    // interval 0 behaves as 1
    do_clear();
    chk("clr_count", {29'd0, entry_count}, 32'd0);
    chk("clr_valid", {31'd0, poll_valid}, 32'd0);
    ins(4'd2, 1'b1, 2'b11, 11'd64, 8'd0, 8'd0);
    wait_poll("i0_first");
    acc();
    for (int f = 0; f < 3; f++) begin
      ticks(2);
      chk("i0_idle", {31'd0, poll_valid}, 32'd0);
      sof();
      tick();
      chk("i0_every_frame", {31'd0, poll_valid}, 32'd1);
      chk("i0_number", {28'd0, poll_number}, 32'd2);
      if (f != 2) acc();
    end

    // backpressure across three frames
    held_num = poll_number;
    held_mps = poll_max_packet;
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      sof_tick = (c == 10 || c == 25 || c == 40);
      tick();
      if (!poll_valid || poll_number != held_num || poll_max_packet != held_mps) stable = 1'b0;
    end
    sof_tick = 1'b0;
    chk("bp_stable", {31'd0, stable}, 32'd1);
    acc();
    chk("bp_released", {31'd0, poll_valid}, 32'd0);
    ticks(6);
    chk("bp_single_poll", {31'd0, poll_valid}, 32'd0);

    // round robin, OUT ignored
    do_clear();
    ins(4'd1, 1'b1, 2'b11, 11'd8, 8'd10, 8'd0);
    ins(4'd2, 1'b0, 2'b11, 11'd8, 8'd10, 8'd0);
    ins(4'd3, 1'b1, 2'b11, 11'd8, 8'd10, 8'd1);
    chk("rr_count", {29'd0, entry_count}, 32'd2);
    wait_poll("rr_w0");
    chk("rr_0", {28'd0, poll_number}, 32'd1);
    acc();
    wait_poll("rr_w1");
    chk("rr_1", {28'd0, poll_number}, 32'd3);
    chk("rr_1_index", {30'd0, poll_index}, 32'd1);
    acc();
    for (int f = 0; f < 10; f++) sof();
    wait_poll("rr_w2");
    chk("rr_2", {28'd0, poll_number}, 32'd1);
    acc();
    wait_poll("rr_w3");
    chk("rr_3", {28'd0, poll_number}, 32'd3);
    acc();
    ticks(4);
    chk("rr_done", {31'd0, poll_valid}, 32'd0);

    // full / overflow
    do_clear();
    ins(4'd1, 1'b1, 2'b11, 11'd8, 8'd10, 8'd0);
    ins(4'd3, 1'b1, 2'b11, 11'd8, 8'd10, 8'd0);
    ins(4'd4, 1'b1, 2'b10, 11'd8, 8'd10, 8'd0);
    ins(4'd5, 1'b1, 2'b11, 11'd8, 8'd10, 8'd0);
    chk("full_count", {29'd0, entry_count}, 32'd4);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    ins(4'd6, 1'b1, 2'b11, 11'd8, 8'd10, 8'd0);
    chk("ovf_after", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {29'd0, entry_count}, 32'd4);
    wait_poll("fl_w0"); chk("fl_0", {28'd0, poll_number}, 32'd1); acc();
    wait_poll("fl_w1"); chk("fl_1", {28'd0, poll_number}, 32'd3); acc();
    wait_poll("fl_w2"); chk("fl_2", {28'd0, poll_number}, 32'd4); acc();
    wait_poll("fl_w3"); chk("fl_3", {28'd0, poll_number}, 32'd5); acc();
    ticks(10);
    chk("fl_ep6_absent", {31'd0, poll_valid}, 32'd0);
    ins(4'd1, 1'b1, 2'b11, 11'd16, 8'd10, 8'd0);
    chk("upd_count", {29'd0, entry_count}, 32'd4);
    wait_poll("upd_w");
    chk("upd_number", {28'd0, poll_number}, 32'd1);
    chk("upd_mps", {21'd0, poll_max_packet}, 32'd16);
    chk("upd_ovf_sticky", {31'd0, overflow}, 32'd1);

    // update of the offered slot: latched fields kept, re-polled with new ones
    ins(4'd1, 1'b1, 2'b11, 11'd32, 8'd10, 8'd0);
    chk("repoll_held_mps", {21'd0, poll_max_packet}, 32'd16);
    acc();
    wait_poll("repoll_w");
    chk("repoll_number", {28'd0, poll_number}, 32'd1);
    chk("repoll_mps", {21'd0, poll_max_packet}, 32'd32);
    acc();

    // reset during an offer
    ins(4'd3, 1'b1, 2'b11, 11'd8, 8'd10, 8'd0);
    wait_poll("rst_mid_w");
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, poll_valid}, 32'd0);
    chk("rst_mid_count", {29'd0, entry_count}, 32'd0);
    chk("rst_mid_ovf", {31'd0, overflow}, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      sof();
      ticks(3);
    end
    chk("rst_no_poll", {31'd0, poll_valid}, 32'd0);
    ins(4'd7, 1'b1, 2'b01, 11'd100, 8'd1, 8'd3);
    wait_poll("rst_new_w");
    chk("rst_new_number", {28'd0, poll_number}, 32'd7);
    chk("rst_new_index", {30'd0, poll_index}, 32'd0);
    chk("rst_new_count", {29'd0, entry_count}, 32'd1);
    acc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
